// File: rtl/normalize_round_unit.sv
// Two-stage normalize / round / pack unit turning a divider-style xx.47 result into an IEEE-754 single.
// Stage 1 normalizes (with denormal right-shift and sticky collection); stage 2 rounds, detects overflow and packs.
module normalize_round_unit #(
  parameter int STICKY_SHIFT_MAX = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [1:0]  rounding_mode,
  input  logic [9:0]  calculated_exponent,
  input  logic [48:0] calculated_fraction,
  input  logic [26:0] remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  function automatic logic [5:0] lzc48(input logic [47:0] v);
    lzc48 = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (v[i]) lzc48 = 6'(47 - i);
    end
  endfunction

  // Returns {overflow, underflow, inexact, result}.
  function automatic logic [34:0] round_pack(input logic s, input logic [1:0] rm, input logic z,
                                             input logic [10:0] e, input logic [47:0] m,
                                             input logic st);
    logic [23:0] sig;
    logic        g, sk, inc, ovf, inx;
    logic [24:0] sum;
    logic [11:0] e_rnd;
    logic [22:0] frac;
    logic [30:0] mag;
    sig = m[47:24];
    g   = m[23];
    sk  = (|m[22:0]) | st;
    case (rm)
      2'b00:   inc = g & (sk | sig[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = !s & (g | sk);
      default: inc = s & (g | sk);
    endcase
    sum = {1'b0, sig} + {24'd0, inc};
    if (e == 11'd0) begin
      // a denormal that rounds up into bit 23 becomes the smallest normal
      e_rnd = {11'd0, sum[23]};
      frac  = sum[22:0];
    end else begin
      e_rnd = {1'b0, e} + {11'd0, sum[24]};
      frac  = sum[24] ? sum[23:1] : sum[22:0];
    end
    ovf = (e_rnd >= 12'd255);
    inx = g | sk | ovf;
    mag = {e_rnd[7:0], frac};
    if (ovf) begin
      case (rm)
        2'b00:   mag = 31'h7F800000;
        2'b01:   mag = 31'h7F7FFFFF;
        2'b10:   mag = s ? 31'h7F7FFFFF : 31'h7F800000;
        default: mag = s ? 31'h7F800000 : 31'h7F7FFFFF;
      endcase
    end
    if (z) round_pack = {3'b000, s, 31'd0};
    else   round_pack = {ovf, (e == 11'd0) & inx, inx, s, mag};
  endfunction

  logic               vld_p1, vld_p2, adv_p1;
  logic               sign_p1, zero_p1, sticky_p1;
  logic [1:0]         rmode_p1;
  logic [10:0]        exp_p1;
  logic [47:0]        mant_p1;

  logic [5:0]         lzc_p0, dsh_p0;
  logic signed [11:0] exp_in_p0, exp_norm_p0, dshift_p0;
  logic [47:0]        mant_norm_p0, mant_p0;
  logic               sticky_norm_p0, sticky_p0;
  logic [10:0]        exp_p0;

  assign adv_p1    = !vld_p2 | out_ready;
  assign in_ready  = reset & (!vld_p1 | adv_p1);
  assign out_valid = vld_p2;
  assign exp_in_p0 = {{2{calculated_exponent[9]}}, calculated_exponent};

  // Stage 0 -> 1: normalize, then denormalize when the exponent falls to zero or below
  always_comb begin
    lzc_p0    = lzc48(calculated_fraction[47:0]);
    dshift_p0 = 12'sd0;
    dsh_p0    = 6'd0;
    if (calculated_fraction[48]) begin
      mant_norm_p0   = calculated_fraction[48:1];
      sticky_norm_p0 = calculated_fraction[0];
      exp_norm_p0    = exp_in_p0 + 12'sd1;
    end else begin
      mant_norm_p0   = calculated_fraction[47:0] << lzc_p0;
      sticky_norm_p0 = 1'b0;
      exp_norm_p0    = exp_in_p0 - signed'({6'd0, lzc_p0});
    end
    mant_p0   = mant_norm_p0;
    sticky_p0 = sticky_norm_p0 | (remainder != 27'd0);
    exp_p0    = exp_norm_p0[10:0];
    if (exp_norm_p0 <= 12'sd0) begin
      dshift_p0 = 12'sd1 - exp_norm_p0;
      dsh_p0    = (dshift_p0 > STICKY_SHIFT_MAX) ? 6'(STICKY_SHIFT_MAX) : dshift_p0[5:0];
      mant_p0   = mant_norm_p0 >> dsh_p0;
      sticky_p0 = sticky_p0 | (|(mant_norm_p0 & ((48'd1 << dsh_p0) - 48'd1)));
      exp_p0    = 11'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      sign_p1   <= sign;
      rmode_p1  <= rounding_mode;
      zero_p1   <= (calculated_fraction == 49'd0);
      exp_p1    <= exp_p0;
      mant_p1   <= mant_p0;
      sticky_p1 <= sticky_p0;
    end
  end

  // Stage 1 -> 2: round and pack into the output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      result    <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (adv_p1) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          {overflow, underflow, inexact, result} <=
            round_pack(sign_p1, rmode_p1, zero_p1, exp_p1, mant_p1, sticky_p1);
        end
      end
    end
  end

endmodule

// File: tb/tb_normalize_round_unit.sv
// Bench for normalize_round_unit: directed corner cases plus random traffic against an exact-arithmetic model.
module tb_normalize_round_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [1:0]  rounding_mode = 2'b00;
  logic [9:0]  calculated_exponent = 10'd0;
  logic [48:0] calculated_fraction = 49'd0;
  logic [26:0] remainder = 27'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow, underflow, inexact;

  normalize_round_unit #(.STICKY_SHIFT_MAX(26)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sign(sign),
    .rounding_mode(rounding_mode), .calculated_exponent(calculated_exponent),
    .calculated_fraction(calculated_fraction), .remainder(remainder),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0, n_emit = 0, occ = 0, cyc = 0;
  int          bp_mode = 0, bp_ph = 0;
  logic [34:0] exp_q[$];
  logic        held_v = 1'b0;
  logic [34:0] held;
  logic [34:0] expv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Value = f * 2^(e-127-47); round to single precision with exact integer arithmetic.
  function automatic logic [34:0] model(input logic s, input logic [1:0] rm, input logic [9:0] ce,
                                        input logic [48:0] f, input logic [26:0] rem);
    longint       e, en, k, bits;
    int           p;
    logic [127:0] v, q, d, half;
    logic         g, st, inc, ovf, den;
    logic [30:0]  mag;
    if (f == 49'd0) return {3'b000, s, 31'd0};
    p = 0;
    for (int i = 0; i < 49; i++) if (f[i]) p = i;
    e  = longint'($signed(ce));
    en = e + longint'(p) - 47;
    // denormal right-shift is capped, which acts like clamping the exponent at -25
    if (en < -25) begin
      e  = e - 25 - en;
      en = -25;
    end
    den = (en <= 0);
    k   = den ? (25 - e) : (longint'(p) - 23);
    v   = 128'(f);
    if (k > 0) begin
      q    = v >> k;
      d    = v & ((128'd1 << k) - 128'd1);
      half = 128'd1 << (k - 1);
      g    = (d >= half);
      st   = (d != 128'd0) && (d != half);
    end else begin
      q  = v << (-k);
      g  = 1'b0;
      st = 1'b0;
    end
    st = st | (rem != 27'd0);
    case (rm)
      2'd0:    inc = g && (st || q[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = !s && (g || st);
      default: inc = s && (g || st);
    endcase
    q = q + 128'(inc);
    if (den) bits = longint'(q[31:0]);
    else     bits = (en - 1) * 8388608 + longint'(q[31:0]);
    ovf = (bits >= 2139095040);
    mag = bits[30:0];
    if (ovf) mag = (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s)) ? 31'h7F800000 : 31'h7F7FFFFF;
    return {ovf, den && (g || st || ovf), g || st || ovf, s, mag};
  endfunction

  task automatic send(input logic s, input logic [1:0] rm, input logic [9:0] e,
                      input logic [48:0] f, input logic [26:0] r);
    logic ok;
    sign = s; rounding_mode = rm; calculated_exponent = e;
    calculated_fraction = f; remainder = r; in_valid = 1'b1;
    exp_q.push_back(model(s, rm, e, f, r));
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    chk("accept", 64'(ok), 64'(1));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(posedge clk);
    chk("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       begin out_ready = (bp_ph % 3 == 0); bp_ph++; end
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      occ    = 0;
      held_v = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
      if (held_v)
        chk("stall_hold", 64'({out_valid, overflow, underflow, inexact, result}), 64'({1'b1, held}));
      if (out_valid && out_ready) begin
        n_emit++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          expv = exp_q.pop_front();
          chk("result", 64'({overflow, underflow, inexact, result}), 64'(expv));
        end
      end
      held_v = out_valid && !out_ready;
      held   = {overflow, underflow, inexact, result};
      occ    = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  initial begin
    int          lat, t0, e0;
    logic [63:0] r64;
    logic [48:0] f;

    #3 reset = 1'b0;
    #4;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_result", 64'({overflow, underflow, inexact, result}), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'(1));
    chk("rel_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;

    send(1'b0, 2'b00, 10'd127, 49'h0_8000_0000_0000, 27'd0);
    lat = 1;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 10);
    chk("latency", 64'(lat), 64'(2));
    chk("one_value", 64'({overflow, underflow, inexact, result}), 64'({3'b000, 32'h3F800000}));
    drain();

    send(1'b0, 2'b00, 10'd127, 49'h1_0000_0000_0000, 27'd0);
    send(1'b0, 2'b00, 10'd127, 49'h0_8000_0080_0000, 27'd0);
    send(1'b0, 2'b00, 10'd127, 49'h0_8000_0080_0000, 27'd1);
    send(1'b0, 2'b00, 10'd255, 49'h0_8000_0000_0000, 27'd0);
    send(1'b0, 2'b01, 10'd255, 49'h0_8000_0000_0000, 27'd0);
    send(1'b1, 2'b10, 10'd255, 49'h0_8000_0000_0000, 27'd0);
    send(1'b0, 2'b00, 10'h3FF, 49'h0_8000_0000_0000, 27'd0);
    send(1'b1, 2'b00, 10'd5, 49'd0, 27'd9);
    send(1'b0, 2'b00, 10'd254, 49'h0_FFFF_FF80_0000, 27'd0);
    send(1'b0, 2'b00, 10'd0, 49'h0_FFFF_FF80_0000, 27'd0);
    send(1'b1, 2'b11, 10'h380, 49'h0_0000_0000_0001, 27'd3);
    drain();

    t0 = cyc;
    for (int i = 0; i < 8; i++)
      send(i[0], 2'(i), 10'(100 + i), 49'h0_C000_0000_0000 + 49'(i), 27'd0);
    chk("throughput", 64'(cyc - t0), 64'(8));
    drain();

    bp_mode = 1;
    bp_ph   = 0;
    e0      = n_emit;
    for (int i = 0; i < 5; i++)
      send(1'b0, 2'b00, 10'(120 + i), 49'h0_9000_0000_0000 + 49'(i << 20), 27'd0);
    drain();
    chk("bp_count", 64'(n_emit - e0), 64'(5));

    bp_mode = 2;
    for (int i = 0; i < 200; i++) begin
      r64 = {$urandom(), $urandom()};
      f   = r64[48:0] >> $urandom_range(0, 50);
      if ($urandom_range(0, 3) == 0) f = f & ~49'h7FFFFF;
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           10'($urandom_range(0, 420)) - 10'd80, f,
           ($urandom_range(0, 1) == 1) ? 27'($urandom_range(1, 1000)) : 27'd0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    bp_mode = 0;
    drain();

    bp_mode = 3;
    @(posedge clk);
    #1;
    send(1'b0, 2'b00, 10'd127, 49'h0_8000_0000_0000, 27'd0);
    send(1'b0, 2'b00, 10'd128, 49'h0_8000_0000_0000, 27'd0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    chk("midrst_result", 64'({overflow, underflow, inexact, result}), 64'(0));
    exp_q.delete();
    bp_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    e0 = n_emit;
    repeat (10) @(posedge clk);
    chk("post_rst_silent", 64'(n_emit - e0), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
